aes_key_expand: RTL
===================

// Module: aes_key_expand
// PURPOSE
//  AES-128 key schedule. Loads a 128-bit cipher key and streams round keys 0..ROUNDS
//  to the AddRoundKey stage (keyadd) over a valid/ready handshake, one key per cycle.
//  Sits directly upstream of keyadd; rk_data connects straight to keyadd.key.
// PARAMETERS
//  ROUNDS  10  number of round keys issued after round key 0 (legal 1..10; 10 = AES-128)
// PORTS
//  clk       in   1         single clock, all logic on posedge
//  reset_n   in   1         synchronous, active-low reset
//  start     in   1         load key and begin schedule (accepted only when busy=0)
//  key       in   [15:0][7:0] cipher key; byte 15 = first key byte (MSB of w0)
//  replay    in   1         reissue cached schedule (see CONFIGURATION); ignored otherwise
//  rk_valid  out  1         rk_data/rk_round hold a valid round key
//  rk_ready  in   1         consumer accepts key when rk_valid & rk_ready
//  rk_data   out  [15:0][7:0] round key, same byte order as key
//  rk_round  out  4         index of rk_data, 0..ROUNDS
//  busy      out  1         schedule in progress (state != IDLE)
//  done      out  1         one-cycle pulse on the cycle after last key accepted
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE; rk_valid=0, rk_data=0, rk_round=0,
//    busy=0, done=0; cache_valid=0. Reset mid-schedule aborts immediately, no done.
//  - FSM: IDLE --start--> RUN --(accept & rk_round==ROUNDS)--> IDLE.
//  - IDLE & start: register key into rk_data, rk_round=0, rk_valid=1 next cycle (latency 1).
//  - start while busy=1: ignored. Simultaneous start & replay in IDLE: start wins.
//  - RUN, accept on round r<ROUNDS: next cycle rk_data=expand(rk_data, RCON[r+1]),
//    rk_round=r+1, rk_valid stays 1 (zero bubbles, 1 key/cycle at full ready).
//  - RUN, accept on round ROUNDS: next cycle rk_valid=0, state=IDLE, done=1 for 1 cycle.
//  - rk_valid & !rk_ready: rk_data, rk_round held stable; no key ever dropped or repeated.
//  - Words: w0=rk[15:12], w1=rk[11:8], w2=rk[7:4], w3=rk[3:0] (higher byte index = MSB).
//  - expand: t = SubWord(RotWord(w3)) ^ {RCON,8'h00,8'h00,8'h00};
//    RotWord{a0,a1,a2,a3}={a1,a2,a3,a0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36 (8-bit, indexed by target round).
//  - SubWord: 4 parallel AES S-boxes, combinational (GF(2^8) inverse mod 11b + affine 63);
//    S(00)=63, S(53)=ed. All arithmetic is bitwise XOR, 8-bit, no carries.
//  - key input sampled only on the start cycle; later changes have no effect.
// CONFIGURATION
//  AESKEY_CACHE_EN defined:
//   - 11x128-bit cache; each issued round key written to cache[rk_round] on accept.
//   - cache_valid set when a full schedule completes (done), cleared by reset or start.
//   - IDLE & replay & cache_valid & !start: reissue cache[0..ROUNDS] with same handshake,
//     latency and done pulse; S-box path unused. replay with cache_valid=0: ignored.
//  AESKEY_CACHE_EN undefined: no cache storage, replay ignored, cache_valid logic absent.
// TESTING
//  1. key=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> round0=key,
//     round1=a0fafe1788542cb123a339392a6c7605, round10=d014f9a8c9ee2589e13f0cc8b6630ca6,
//     11 consecutive valid cycles, done pulse 1 cycle later.
//  2. key=0, rk_ready toggled 1/0 each cycle -> round1=62636363626363636263636362636363,
//     rk_data/rk_round stable while stalled, exactly 11 accepts.
//  3. start re-asserted at round 4 with different key -> ignored, schedule of first key
//     completes unchanged.
//  4. reset_n=0 at round 6 -> next cycle rk_valid=0, busy=0, no done; new start runs
//     clean from round 0.
//  5. ROUNDS=2 -> exactly 3 keys (rounds 0,1,2) then done.
//  6. AESKEY_CACHE_EN: after test 1, replay -> identical 11 keys from vector 1;
//     start with new key then replay before completion -> replay ignored.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// Round-key stream interface for aes_key_expand.
// The "slave" modport is the key expander itself: it takes start/key/replay and
// rk_ready, and drives the round-key stream plus busy/done status.
// The "master" modport is the controller/consumer side.
interface aes_key_expand_if;
    logic             start;
    logic [15:0][7:0] key;
    logic             replay;
    logic             rk_valid;
    logic             rk_ready;
    logic [15:0][7:0] rk_data;
    logic [3:0]       rk_round;
    logic             busy;
    logic             done;

    modport master (
        output start, key, replay, rk_ready,
        input  rk_valid, rk_data, rk_round, busy, done
    );

    modport slave (
        input  start, key, replay, rk_ready,
        output rk_valid, rk_data, rk_round, busy, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule.
// Loads a 128-bit cipher key on start and streams round keys 0..ROUNDS, one per
// accepted handshake, straight into the AddRoundKey stage.
// Optional feature macro: AESKEY_CACHE_EN
//   defined   -> the issued schedule is cached and can be reissued with replay
//   undefined -> no cache storage, replay is ignored
module aes_key_expand #(
    parameter int ROUNDS = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    aes_key_expand_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    // GF(2^8) multiply by x, reduced by the AES polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) shift-and-add multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        logic [7:0] inv;
        x = a;
        for (int i = 0; i < 6; i++) begin
            x = gf_mul(gf_mul(x, x), a);   // a^3, a^7, ... a^127
        end
        inv = gf_mul(x, x);                // a^254
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant, indexed by the round being produced.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule step: w0 is the most significant word.
    function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] w0n;
        logic [31:0] w1n;
        logic [31:0] w2n;
        logic [31:0] w3n;
        rot = {rk[23:0], rk[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h000000};
        w0n = rk[127:96] ^ t;
        w1n = rk[95:64]  ^ w0n;
        w2n = rk[63:32]  ^ w1n;
        w3n = rk[31:0]   ^ w2n;
        return {w0n, w1n, w2n, w3n};
    endfunction

    state_t       state;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;
    logic         accept;
    logic [3:0]   next_round;
    logic [127:0] next_key;

    assign accept     = rk_valid && bus.rk_ready;
    assign next_round = rk_round + 4'd1;

`ifdef AESKEY_CACHE_EN
    logic [127:0] cache [0:10];
    logic         cache_valid;
    logic         replaying;

    // Record every key issued by a fresh schedule at the slot of its round.
    // NOTE: the cache array has no reset; cache_valid alone says whether it may be read.
    always_ff @(posedge clk) begin
        if (accept && !replaying) cache[rk_round] <= rk_data;
    end
`else
    logic unused_replay;
    assign unused_replay = bus.replay;
`endif

    // Select the key that follows the current one: computed or replayed from cache.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
        next_key = expand(rk_data, rcon(next_round));
`ifdef AESKEY_CACHE_EN
        if (replaying) next_key = cache[next_round];
`endif
    end

    // Schedule FSM with registered stream and status outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update together.
        if (!reset_n) begin
            state    <= IDLE;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef AESKEY_CACHE_EN
            cache_valid <= 1'b0;
            replaying   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        rk_data  <= bus.key;
                        rk_round <= '0;
`ifdef AESKEY_CACHE_EN
                        cache_valid <= 1'b0;
                        replaying   <= 1'b0;
`endif
                    end
`ifdef AESKEY_CACHE_EN
                    else if (bus.replay && cache_valid) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rk_valid  <= 1'b1;
                        rk_data   <= cache[0];
                        rk_round  <= '0;
                        replaying <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    if (accept) begin
                        if (rk_round == LAST_ROUND) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
`ifdef AESKEY_CACHE_EN
                            cache_valid <= 1'b1;
                            replaying   <= 1'b0;
`endif
                        end else begin
                            rk_round <= next_round;
                            rk_data  <= next_key;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rk_valid = rk_valid;
    assign bus.rk_data  = rk_data;
    assign bus.rk_round = rk_round;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
